// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter in front of a single synchronous-read data RAM port
// Port A is the core data interface, port B the debug/DMA loader; responses return one cycle after grant.
module ram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 4,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [SEL_W-1:0]  a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [SEL_W-1:0]  b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic [SEL_W-1:0]  ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  owner_t            last_grant;
  owner_t            resp_owner;
  logic              resp_valid;
  logic              resp_read;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic [15:0]       conflict_q;
  logic              pick_b;

  // Contention tie-break: round-robin, or A-first with a starvation release for B.
  always_comb begin
    pick_b = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick_b = (wait_cnt == 4'(MAX_WAIT));
    end else begin
      pick_b = (last_grant == OWN_A);
    end
  end

  assign a_gnt = !rst && a_req && (!b_req || !pick_b);
  assign b_gnt = !rst && b_req && (!a_req || pick_b);

  assign ram_en = a_gnt | b_gnt;

  always_comb begin
    ram_write_en   = '0;
    ram_addr       = '0;
    ram_write_data = '0;
    if (a_gnt) begin
      ram_write_en   = a_we;
      ram_addr       = a_addr;
      ram_write_data = a_wdata;
    end else if (b_gnt) begin
      ram_write_en   = b_we;
      ram_addr       = b_addr;
      ram_write_data = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_B;
      wait_cnt   <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= OWN_A;
      resp_read  <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      conflict_q <= 16'd0;
    end else begin
      if (a_gnt) begin
        last_grant <= OWN_A;
      end else if (b_gnt) begin
        last_grant <= OWN_B;
      end

      if (b_gnt) begin
        wait_cnt <= 4'd0;
      end else if (b_req && wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      resp_valid <= a_gnt | b_gnt;
      resp_owner <= b_gnt ? OWN_B : OWN_A;
      resp_read  <= (ram_write_en == '0);

      // Read data arrives during the response cycle; keep it so write acks leave rdata unchanged.
      if (a_rvalid && resp_read) begin
        a_rdata_q <= ram_read_data;
      end
      if (b_rvalid && resp_read) begin
        b_rdata_q <= ram_read_data;
      end

      if (a_req && b_req && conflict_q != 16'hFFFF) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign a_rvalid     = resp_valid && (resp_owner == OWN_A);
  assign b_rvalid     = resp_valid && (resp_owner == OWN_B);
  assign a_rdata      = (a_rvalid && resp_read) ? ram_read_data : a_rdata_q;
  assign b_rdata      = (b_rvalid && resp_read) ? ram_read_data : b_rdata_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized scoreboard bench for ram_port_arbiter
// Reference keeps a word-level memory image and per-port expected response queues.
module tb_ram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_req, b_req;
  logic [SW-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en;
  logic [SW-1:0] ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data, ram_read_data;
  logic [15:0]   conflict_cnt;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .conflict_cnt(conflict_cnt)
  );

  // Second instance in fixed-priority mode, exercised only for its grant pattern.
  logic          f_req;
  logic [SW-1:0] f_we;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata, f_rd_in;
  logic          f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_ram_en;
  logic [DW-1:0] f_a_rdata, f_b_rdata, f_ram_wd;
  logic [SW-1:0] f_ram_we;
  logic [AW-1:0] f_ram_addr;
  logic [15:0]   f_conf;

  ram_port_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(4)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(f_req), .a_we(f_we), .a_addr(f_addr), .a_wdata(f_wdata),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(f_req), .b_we(f_we), .b_addr(f_addr), .b_wdata(f_wdata),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
    .ram_en(f_ram_en), .ram_write_en(f_ram_we), .ram_addr(f_ram_addr),
    .ram_write_data(f_ram_wd), .ram_read_data(f_rd_in),
    .conflict_cnt(f_conf)
  );

  // Environment RAM: synchronous read, byte-enabled write.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_read_data <= mem[ram_addr[5:0]];
      for (int k = 0; k < SW; k++)
        if (ram_write_en[k]) mem[ram_addr[5:0]][8*k +: 8] <= ram_write_data[8*k +: 8];
    end
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  int            npass = 0;
  int            nchk  = 0;
  int            cyc   = 0;
  logic [DW-1:0] ref_mem [0:63];
  exp_t          qa[$];
  exp_t          qb[$];
  bit            m_last_b;
  int            m_conf;
  logic [DW-1:0] m_last_a, m_last_bd;
  bit            eg_a, eg_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic serve(input bit pb, input logic [SW-1:0] we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    exp_t e;
    int   idx;
    idx   = int'(addr[5:0]);
    e.cyc = cyc;
    if (we == '0) begin
      e.data = ref_mem[idx];
      if (pb) m_last_bd = e.data; else m_last_a = e.data;
    end else begin
      for (int k = 0; k < SW; k++)
        if (we[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      e.data = pb ? m_last_bd : m_last_a;
    end
    if (pb) qb.push_back(e); else qa.push_back(e);
    m_last_b = pb;
  endtask

  // Reference model: grant rules, RAM drive and conflict counting, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_last_b  = 1'b1;
      m_conf    = 0;
      m_last_a  = '0;
      m_last_bd = '0;
      eg_a      = 1'b0;
      eg_b      = 1'b0;
      chk("reset_outputs",
          {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, conflict_cnt}, 64'd0);
      chk("reset_rdata", {a_rdata, b_rdata}, 64'd0);
    end else begin
      logic [SW-1:0] xwe;
      logic [AW-1:0] xaddr;
      logic [DW-1:0] xwd;
      eg_a = a_req && (!b_req || m_last_b);
      eg_b = b_req && !eg_a;
      chk("a_gnt", a_gnt, eg_a);
      chk("b_gnt", b_gnt, eg_b);
      chk("ram_en", ram_en, eg_a | eg_b);
      xwe   = eg_a ? a_we    : (eg_b ? b_we    : '0);
      xaddr = eg_a ? a_addr  : (eg_b ? b_addr  : '0);
      xwd   = eg_a ? a_wdata : (eg_b ? b_wdata : '0);
      chk("ram_write_en", ram_write_en, xwe);
      chk("ram_addr", ram_addr, xaddr);
      chk("ram_write_data", ram_write_data, xwd);
      chk("conflict_cnt", conflict_cnt, m_conf);
      if (a_req && b_req && m_conf < 65535) m_conf++;
      if (eg_a) serve(1'b0, a_we, a_addr, a_wdata);
      if (eg_b) serve(1'b1, b_we, b_addr, b_wdata);
    end
  end

  // Monitor: responses must appear exactly in the cycle after their grant.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      bit   exp_rv;
      exp_t e;
      while (qa.size() > 0 && qa[0].cyc < cyc) void'(qa.pop_front());
      exp_rv = (qa.size() > 0 && qa[0].cyc == cyc);
      chk("a_rvalid", a_rvalid, exp_rv);
      if (exp_rv) begin
        e = qa.pop_front();
        if (a_rvalid) chk("a_rdata", a_rdata, e.data);
      end
      while (qb.size() > 0 && qb[0].cyc < cyc) void'(qb.pop_front());
      exp_rv = (qb.size() > 0 && qb[0].cyc == cyc);
      chk("b_rvalid", b_rvalid, exp_rv);
      if (exp_rv) begin
        e = qb.pop_front();
        if (b_rvalid) chk("b_rdata", b_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int pa, input int pb);
    for (int i = 0; i < n; i++) begin
      if (!a_req || eg_a) begin
        a_req   = ($urandom % 100) < pa;
        a_we    = ($urandom % 2) ? SW'($urandom) : '0;
        a_addr  = AW'($urandom % 64);
        a_wdata = $urandom;
      end
      if (!b_req || eg_b) begin
        b_req   = ($urandom % 100) < pb;
        b_we    = ($urandom % 2) ? SW'($urandom) : '0;
        b_addr  = AW'($urandom % 64);
        b_wdata = $urandom;
      end
      step();
    end
  endtask

  initial begin
    int fw;
    bit fexp_b, fprev_b;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = i * 32'h9E3779B1;
      ref_mem[i] = i * 32'h9E3779B1;
    end
    mem[16]       = 32'hDEADBEEF;
    ref_mem[16]   = 32'hDEADBEEF;
    ram_read_data = '0;
    rst = 1'b1;
    a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
    f_req = 1'b0; f_we = '0; f_addr = '0; f_wdata = '0; f_rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // A-only read of the DEADBEEF word
    a_req = 1'b1; a_we = '0; a_addr = 32'h10;
    step();
    a_req = 1'b0;
    step();

    // Partial write by A, then B reads the same word
    a_req = 1'b1; a_we = 4'b0011; a_addr = 32'h20; a_wdata = 32'h12345678;
    #3 chk("partial_we", ram_write_en, 4'b0011);
    step();
    a_req = 1'b0; b_req = 1'b1; b_we = '0; b_addr = 32'h20;
    step();
    b_req = 1'b0;
    step();

    // Six contended read cycles
    a_req = 1'b1; a_we = '0; a_addr = 32'h5;
    b_req = 1'b1; b_we = '0; b_addr = 32'h6;
    repeat (6) step();
    a_req = 1'b0; b_req = 1'b0;
    chk("conflict_6", conflict_cnt, 16'd6);
    step();

    // Reset in the cycle after a B grant
    b_req = 1'b1; b_we = '0; b_addr = 32'h7;
    step();
    b_req = 1'b0; rst = 1'b1;
    #1 chk("rst_kills_b_rvalid", b_rvalid, 1'b0);
    step();
    step();
    rst = 1'b0;
    a_req = 1'b1; a_addr = 32'h8; b_req = 1'b1; b_addr = 32'h9;
    #3 chk("post_reset_a_first", {a_gnt, b_gnt}, 2'b10);
    step();
    a_req = 1'b0; b_req = 1'b0;
    step();

    run(3000, 60, 60);
    run(1500, 30, 90);
    a_req = 1'b0; b_req = 1'b0;
    step(); step();

    // Long fully-contended run drives the conflict counter into saturation
    run(65540, 100, 100);
    a_req = 1'b0; b_req = 1'b0;
    step(); step(); step();
    chk("conflict_saturated", conflict_cnt, 16'hFFFF);
    chk("queues_drained", qa.size() + qb.size(), 0);

    // Fixed-priority instance: B is forced through after MAX_WAIT lost cycles
    fw = 0;
    fprev_b = 1'b0;
    f_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fexp_b = (fw == 4);
      chk("fp_a_gnt", f_a_gnt, !fexp_b);
      chk("fp_b_gnt", f_b_gnt, fexp_b);
      chk("fp_b_rvalid", f_b_rvalid, fprev_b);
      fw = fexp_b ? 0 : fw + 1;
      fprev_b = fexp_b;
    end
    @(posedge clk);
    #1 f_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous-read data RAM port between two requesters:
  - Port A: Core data-memory interface.
  - Port B: debug/DMA loader.
- Sits between Core/loader and the RAM instance; drives the RAM's ram_en/ram_write_en/ram_addr/ram_write_data.
- Routes ram_read_data back to the owning requester with a response strobe.
- Arbitration is round-robin or A-priority with a starvation guard; a saturating conflict counter is kept for debug.

Parameters:
ADDR_W, 32, address width (matches ADDR_BUS)
DATA_W, 32, data width (matches DATA_BUS)
SEL_W, 4, byte write-enable width (matches MEM_SEL_BUS)
FIXED_PRIO, 0, 0 = round-robin; 1 = port A wins contention
MAX_WAIT, 4, FIXED_PRIO=1 only: contended cycles B may lose consecutively before B is forced through (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
a_req  in  1  port A access request
a_we  in  SEL_W  port A byte write enables; 0 = read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  port A request accepted this cycle (combinational)
a_rvalid  out  1  port A response strobe, cycle after a_gnt
a_rdata  out  DATA_W  port A read data, valid with a_rvalid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
ram_en  out  1  RAM enable
ram_write_en  out  SEL_W  RAM byte write enables
ram_addr  out  ADDR_W  RAM address
ram_write_data  out  DATA_W  RAM write data
ram_read_data  in  DATA_W  RAM read data, one cycle after ram_en
conflict_cnt  out  16  saturating count of cycles with a_req & b_req

Behaviour:
- Reset (async, rst=1):
  - a_rvalid, b_rvalid, conflict_cnt = 0; a_rdata, b_rdata = 0.
  - last_grant = B, so A wins the first contended cycle; wait_cnt = 0.
  - Any in-flight response is discarded.
- Requester rule: req/we/addr/wdata held stable until gnt is seen. Arbiter accepts at most one access per cycle.
- Grant (combinational, same cycle):
  - One requester only: it is granted.
  - Both requesting, FIXED_PRIO=0: grant the port not in last_grant.
  - Both requesting, FIXED_PRIO=1: grant A, unless wait_cnt == MAX_WAIT; then grant B.
  - No requester: no grant.
- RAM drive:
  - ram_en = a_gnt | b_gnt.
  - ram_write_en/ram_addr/ram_write_data are muxed from the granted port.
  - With no grant they are 0.
- State updates on each clk edge:
  - last_grant updates on any grant.
  - wait_cnt increments when B requests and is not granted; it clears to 0 when b_gnt=1.
- Response pipeline (1-cycle latency):
  - Registered owner tag plus valid bit.
  - Cycle after a_gnt: a_rvalid=1 for both reads and writes (write acknowledge).
  - For a read, a_rdata = ram_read_data captured from that cycle. For a write, a_rdata holds its previous value.
  - Port B is identical.
  - rvalid is a single-cycle pulse per grant.
  - Back-to-back grants give back-to-back rvalids, alternating ports as granted.
- A requester may assert req again in the cycle its rvalid arrives; it may be granted that same cycle.
- conflict_cnt increments on every cycle with a_req & b_req, saturating at 16'hFFFF.
- Same-address read/write in consecutive cycles (different ports): RAM ordering applies; the earlier-granted access completes first.
- rst asserted mid-burst: outputs clear immediately; first post-reset contention goes to A.

Test Plan:
- Only A reads addr 0x10 (RAM holds 0xDEADBEEF):
  - a_gnt same cycle, ram_en=1, ram_write_en=0.
  - Next cycle a_rvalid=1, a_rdata=0xDEADBEEF; b_rvalid stays 0.
- FIXED_PRIO=0, A and B both request reads continuously for 6 cycles:
  - Grants go A,B,A,B,A,B; rvalids alternate one cycle later; conflict_cnt=6.
- FIXED_PRIO=1, MAX_WAIT=4, both request continuously:
  - Grants go A,A,A,A,B,A,A,A,A,B; wait_cnt returns to 0 after each B grant.
- A writes 0x12345678 to 0x20 with a_we=4'b0011, then B reads 0x20 next cycle:
  - ram_write_en=4'b0011 in cycle 1.
  - b_rdata low half = 0x5678, upper bytes equal their prior RAM contents.
- Reset mid-traffic: rst=1 in the cycle after b_gnt:
  - b_rvalid never pulses; all outputs 0.
  - After release, simultaneous requests grant A first.
- conflict_cnt preset near saturation (force or 65537 contended cycles): counter holds at 16'hFFFF with no wrap.
